gen_scheduler: RTL

Sequences one Game-of-Life generation across the ping-pong line BRAMs and arbitrates the current bank's single read port between the display path and the next-state engine. It issues row reads in toroidal order (top/middle/bottom), starts the engine per row, and writes results into the other bank. It swaps banks only on a frame boundary, so the display never shows a half-computed grid. Pause and single-step come from the AXI-Lite register file.

---
 rtl/gen_scheduler.sv | 238 +++++++++++++++++++++++
 1 files changed

// File: rtl/gen_scheduler.sv
// -----------------------------------------------------------------------------
// gen_scheduler
//
// Sequences one Game-of-Life generation across the ping-pong line BRAMs.
// The current bank (cur_bank) is both displayed and read by the next-state
// engine. Its single read port is shared, and the display always wins.
// Result rows are written into the other bank. The banks swap only on a
// display frame boundary, so a half-computed grid is never shown.
//
// Ports
//   out_stream_aclk        clock for all logic
//   periph_resetn          asynchronous active-low reset
//   pause / step           run control, sampled only in IDLE
//   init_busy              loader active; aborts any generation in progress
//   frame_start            display start-of-frame pulse; releases a bank swap
//   disp_req / disp_addr   display row read request (highest priority)
//   calc_done              engine finished the current row
//   ram_rd_en / ram_rd_addr  read port of the current bank
//   cur_bank               bank being displayed and read (0 = A, 1 = B)
//   disp_valid             display data on douta this cycle
//   eng_row_valid / eng_row_slot  engine data on douta and its line-buffer slot
//   calc_go / calc_row     engine start pulse and row being computed
//   wr_en / wr_addr        write port of bank ~cur_bank
//   gen_done / gen_count   swap pulse and completed-generation counter
//   busy                   high in any state other than IDLE
// -----------------------------------------------------------------------------
module gen_scheduler #(
  parameter int Y_SIZE  = 720,
  parameter int Y_WIDTH = $clog2(Y_SIZE)
) (
  input  logic               out_stream_aclk,
  input  logic               periph_resetn,
  input  logic               pause,
  input  logic               step,
  input  logic               init_busy,
  input  logic               frame_start,
  input  logic               disp_req,
  input  logic [Y_WIDTH-1:0] disp_addr,
  input  logic               calc_done,
  output logic               ram_rd_en,
  output logic [Y_WIDTH-1:0] ram_rd_addr,
  output logic               cur_bank,
  output logic               disp_valid,
  output logic               eng_row_valid,
  output logic [1:0]         eng_row_slot,
  output logic               calc_go,
  output logic [Y_WIDTH-1:0] calc_row,
  output logic               wr_en,
  output logic [Y_WIDTH-1:0] wr_addr,
  output logic               gen_done,
  output logic [31:0]        gen_count,
  output logic               busy
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_PRIME,
    S_CALC,
    S_WRITE,
    S_ADVANCE,
    S_DONE
  } state_t;

  // Line-buffer slot codes.
  localparam logic [1:0] SLOT_TOP   = 2'd0;
  localparam logic [1:0] SLOT_MID   = 2'd1;
  localparam logic [1:0] SLOT_BOT   = 2'd2;
  localparam logic [1:0] SLOT_SHIFT = 2'd3;

  localparam logic [Y_WIDTH-1:0] ROW_LAST   = Y_WIDTH'(Y_SIZE - 1);
  localparam logic [Y_WIDTH-1:0] ROW_PENULT = Y_WIDTH'(Y_SIZE - 2);

  state_t             r_state;
  logic [Y_WIDTH-1:0] r_row;        // row being computed (r)
  logic [1:0]         r_prime_idx;  // which of the three priming reads is next
  logic               r_cur_bank;
  logic               r_disp_valid;
  logic               r_eng_valid;
  logic [1:0]         r_eng_slot;
  logic               r_calc_go;
  logic               r_wr_en;
  logic               r_gen_done;
  logic [31:0]        r_gen_count;
  logic               r_busy;

  logic               w_eng_req;
  logic               w_eng_grant;
  logic [Y_WIDTH-1:0] w_eng_addr;
  logic [1:0]         w_eng_slot;

  // Engine read request for the current state. The row below r+1 is r+2,
  // which wraps to 0 only when r is the second-to-last row.
  // NOTE: every signal written in always_comb gets a default first, so no
  // path leaves it unassigned and no latch is inferred.
  always_comb begin
    w_eng_req  = 1'b0;
    w_eng_addr = '0;
    w_eng_slot = SLOT_TOP;
    case (r_state)
      S_PRIME: begin
        w_eng_req = 1'b1;
        case (r_prime_idx)
          2'd0: begin
            w_eng_addr = ROW_LAST;
            w_eng_slot = SLOT_TOP;
          end
          2'd1: begin
            w_eng_addr = '0;
            w_eng_slot = SLOT_MID;
          end
          default: begin
            w_eng_addr = Y_WIDTH'(1);
            w_eng_slot = SLOT_BOT;
          end
        endcase
      end
      S_ADVANCE: begin
        w_eng_req  = 1'b1;
        w_eng_addr = (r_row == ROW_PENULT) ? '0 : r_row + Y_WIDTH'(2);
        w_eng_slot = SLOT_SHIFT;
      end
      default: ;
    endcase
  end

  // The display owns the port whenever it asks; an engine read waits.
  assign w_eng_grant = w_eng_req & ~disp_req;
  assign ram_rd_en   = disp_req | w_eng_req;
  assign ram_rd_addr = disp_req ? disp_addr : w_eng_addr;

  // NOTE: sequential state uses non-blocking assignments only, so every
  // register samples the pre-edge values of the others.
  always_ff @(posedge out_stream_aclk or negedge periph_resetn) begin
    if (!periph_resetn) begin
      r_state      <= S_IDLE;
      r_row        <= '0;
      r_prime_idx  <= 2'd0;
      r_cur_bank   <= 1'b0;
      r_disp_valid <= 1'b0;
      r_eng_valid  <= 1'b0;
      r_eng_slot   <= SLOT_TOP;
      r_calc_go    <= 1'b0;
      r_wr_en      <= 1'b0;
      r_gen_done   <= 1'b0;
      r_gen_count  <= '0;
      r_busy       <= 1'b0;
    end else begin
      // BRAM read latency is one cycle: the valids trail the grants by one.
      r_disp_valid <= disp_req;
      r_eng_valid  <= w_eng_grant;
      r_eng_slot   <= w_eng_grant ? w_eng_slot : SLOT_TOP;
      r_calc_go    <= 1'b0;
      r_wr_en      <= 1'b0;
      r_gen_done   <= 1'b0;

      if (init_busy) begin
        // The loader is rewriting the grid. Drop the partial generation,
        // including a read landing next cycle. Bank and count are kept.
        r_state     <= S_IDLE;
        r_row       <= '0;
        r_prime_idx <= 2'd0;
        r_eng_valid <= 1'b0;
        r_eng_slot  <= SLOT_TOP;
        r_busy      <= 1'b0;
      end else begin
        case (r_state)
          S_IDLE: begin
            if (!pause || step) begin
              r_state     <= S_PRIME;
              r_row       <= '0;
              r_prime_idx <= 2'd0;
              r_busy      <= 1'b1;
            end
          end

          S_PRIME: begin
            if (w_eng_grant) begin
              if (r_prime_idx == 2'd2) begin
                r_prime_idx <= 2'd0;
                r_state     <= S_CALC;
                r_calc_go   <= 1'b1;
              end else begin
                r_prime_idx <= r_prime_idx + 2'd1;
              end
            end
          end

          S_CALC: begin
            if (calc_done) begin
              r_state <= S_WRITE;
              r_wr_en <= 1'b1;
            end
          end

          S_WRITE: begin
            r_state <= (r_row == ROW_LAST) ? S_DONE : S_ADVANCE;
          end

          S_ADVANCE: begin
            if (w_eng_grant) begin
              r_row     <= r_row + Y_WIDTH'(1);
              r_state   <= S_CALC;
              r_calc_go <= 1'b1;
            end
          end

          S_DONE: begin
            if (frame_start) begin
              r_cur_bank  <= ~r_cur_bank;
              r_gen_done  <= 1'b1;
              r_gen_count <= r_gen_count + 32'd1;
              r_state     <= S_IDLE;
              r_busy      <= 1'b0;
            end
          end

          default: begin
            r_state <= S_IDLE;
            r_busy  <= 1'b0;
          end
        endcase
      end
    end
  end

  assign cur_bank      = r_cur_bank;
  assign disp_valid    = r_disp_valid;
  assign eng_row_valid = r_eng_valid;
  assign eng_row_slot  = r_eng_slot;
  assign calc_go       = r_calc_go;
  assign calc_row      = r_row;
  assign wr_en         = r_wr_en;
  assign wr_addr       = r_row;
  assign gen_done      = r_gen_done;
  assign gen_count     = r_gen_count;
  assign busy          = r_busy;

endmodule
